// File: rtl/ctl_game.sv
// Duck Hunt game-flow controller: waves of NUM_DUCKS ducks, per-wave ammo, saturating BCD score.
// Optional perfect-wave bonus is compiled in when GAME_PERFECT_BONUS_EN is defined.
module ctl_game #(
  parameter int NUM_DUCKS    = 2,
  parameter int AMMO         = 3,
  parameter int WAVES        = 10,
  parameter int SCORE_DIGITS = 2,
  parameter int FLY_FRAMES   = 300,
  parameter int PAUSE_FRAMES = 60,
  localparam int IDW = (NUM_DUCKS > 1) ? $clog2(NUM_DUCKS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      new_frame,
  input  logic                      start,
  input  logic                      shot_fired,
  input  logic                      hit,
  input  logic [IDW-1:0]            hit_id,
  output logic [NUM_DUCKS-1:0]      duck_launch,
  output logic [NUM_DUCKS-1:0]      duck_active,
  output logic [3:0]                ammo_bcd,
  output logic [4*SCORE_DIGITS-1:0] score_bcd,
  output logic [7:0]                wave_bcd,
  output logic [2:0]                state,
  output logic                      game_over
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_FLY    = 3'd2,
    S_PAUSE  = 3'd3,
    S_OVER   = 3'd4
  } state_e;

  localparam int FMAX = (FLY_FRAMES > PAUSE_FRAMES) ? FLY_FRAMES : PAUSE_FRAMES;
  localparam int FCW  = $clog2(FMAX + 1);
  localparam logic [FCW-1:0]            FLY_LAST   = FCW'(FLY_FRAMES - 1);
  localparam logic [FCW-1:0]            PAUSE_LAST = FCW'(PAUSE_FRAMES - 1);
  localparam logic [3:0]                AMMO_V     = 4'(AMMO);
  localparam logic [7:0]                WAVES_BCD  = {4'(WAVES / 10), 4'(WAVES % 10)};
  localparam logic [4*SCORE_DIGITS-1:0] SCORE_MAX  = {SCORE_DIGITS{4'h9}};

  state_e                    state_q, state_d;
  logic [3:0]                ammo_q, ammo_d;
  logic [4*SCORE_DIGITS-1:0] score_q, score_d;
  logic [7:0]                wave_q, wave_d;
  logic [NUM_DUCKS-1:0]      active_q, active_d;
  logic [NUM_DUCKS-1:0]      launch_q, launch_d;
  logic [FCW-1:0]            fcnt_q, fcnt_d;
  logic                      over_q;
`ifdef GAME_PERFECT_BONUS_EN
  logic [2:0]                bonus_q, bonus_d;
`endif

  logic [NUM_DUCKS-1:0] hit_mask;
  logic                 hit_valid;
  logic                 fly_timeout;
  logic [7:0]           wave_inc;

  function automatic logic [4*SCORE_DIGITS-1:0] bcd_inc(input logic [4*SCORE_DIGITS-1:0] v);
    logic [4*SCORE_DIGITS-1:0] r;
    logic                      carry;
    r     = v;
    carry = 1'b1;
    if (v != SCORE_MAX) begin
      for (int unsigned i = 0; i < SCORE_DIGITS; i++) begin
        if (carry) begin
          if (v[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = v[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // Out-of-range ids decode to an empty mask, so they can never score.
  always_comb begin
    hit_mask = '0;
    for (int unsigned i = 0; i < NUM_DUCKS; i++) begin
      if (hit_id == IDW'(i)) hit_mask[i] = 1'b1;
    end
  end

  assign hit_valid   = hit && (|(hit_mask & active_q));
  assign fly_timeout = new_frame && (fcnt_q == FLY_LAST);
  assign wave_inc    = (wave_q[3:0] == 4'd9) ? {wave_q[7:4] + 4'd1, 4'd0}
                                             : {wave_q[7:4], wave_q[3:0] + 4'd1};

  always_comb begin
    state_d  = state_q;
    ammo_d   = ammo_q;
    score_d  = score_q;
    wave_d   = wave_q;
    active_d = active_q;
    launch_d = '0;
    fcnt_d   = fcnt_q;
`ifdef GAME_PERFECT_BONUS_EN
    bonus_d  = bonus_q;
`endif
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          score_d = '0;
          wave_d  = 8'h01;
          ammo_d  = AMMO_V;
          state_d = S_LAUNCH;
`ifdef GAME_PERFECT_BONUS_EN
          bonus_d = '0;
`endif
        end
      end
      S_LAUNCH: begin
        launch_d = '1;
        active_d = '1;
        fcnt_d   = '0;
        state_d  = S_FLY;
      end
      S_FLY: begin
        if (shot_fired && (ammo_q != 4'd0)) ammo_d = ammo_q - 4'd1;
        if (hit_valid) begin
          active_d = active_q & ~hit_mask;
          score_d  = bcd_inc(score_q);
        end
        if (new_frame) fcnt_d = fcnt_q + FCW'(1);
        // A hit arriving with the last round keeps FLY open for that cycle.
        if ((active_d == '0) || ((ammo_d == 4'd0) && !hit) || fly_timeout) begin
`ifdef GAME_PERFECT_BONUS_EN
          if (active_d == '0) bonus_d = 3'(NUM_DUCKS);
`endif
          active_d = '0;
          fcnt_d   = '0;
          state_d  = S_PAUSE;
        end
      end
      S_PAUSE: begin
`ifdef GAME_PERFECT_BONUS_EN
        if (bonus_q != 3'd0) begin
          bonus_d = bonus_q - 3'd1;
          score_d = bcd_inc(score_q);
        end
`endif
        if (new_frame) begin
          if (fcnt_q == PAUSE_LAST) begin
            fcnt_d = '0;
`ifdef GAME_PERFECT_BONUS_EN
            bonus_d = '0;
`endif
            if (wave_q == WAVES_BCD) begin
              state_d = S_OVER;
            end else begin
              wave_d  = wave_inc;
              ammo_d  = AMMO_V;
              state_d = S_LAUNCH;
            end
          end else begin
            fcnt_d = fcnt_q + FCW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      ammo_q   <= AMMO_V;
      score_q  <= '0;
      wave_q   <= '0;
      active_q <= '0;
      launch_q <= '0;
      fcnt_q   <= '0;
      over_q   <= 1'b0;
`ifdef GAME_PERFECT_BONUS_EN
      bonus_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ammo_q   <= ammo_d;
      score_q  <= score_d;
      wave_q   <= wave_d;
      active_q <= active_d;
      launch_q <= launch_d;
      fcnt_q   <= fcnt_d;
      over_q   <= (state_d == S_OVER);
`ifdef GAME_PERFECT_BONUS_EN
      bonus_q  <= bonus_d;
`endif
    end
  end

  assign duck_launch = launch_q;
  assign duck_active = active_q;
  assign ammo_bcd    = ammo_q;
  assign score_bcd   = score_q;
  assign wave_bcd    = wave_q;
  assign state       = state_q;
  assign game_over   = over_q;

endmodule

// File: tb/tb_ctl_game.sv
// Bench for ctl_game: integer-level game model checked every cycle plus directed literal checks.
module tb_ctl_game;

`ifdef GAME_PERFECT_BONUS_EN
  localparam bit BONUS = 1'b1;
  localparam int SC_W1 = 32'h04;
`else
  localparam bit BONUS = 1'b0;
  localparam int SC_W1 = 32'h02;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic nf1, st1, sh1, h1;
  logic [0:0] id1;
  logic nf2, st2, sh2, h2;
  logic [1:0] id2;

  logic [1:0] l1, a1;
  logic [3:0] am1;
  logic [7:0] sc1, wv1;
  logic [2:0] s1;
  logic       go1;
  logic [3:0] l2, a2, am2, sc2;
  logic [7:0] wv2;
  logic [2:0] s2;
  logic       go2;

  ctl_game u_dut (
    .clk(clk), .rst(rst_n), .new_frame(nf1), .start(st1), .shot_fired(sh1),
    .hit(h1), .hit_id(id1), .duck_launch(l1), .duck_active(a1), .ammo_bcd(am1),
    .score_bcd(sc1), .wave_bcd(wv1), .state(s1), .game_over(go1)
  );

  ctl_game #(
    .NUM_DUCKS(4), .AMMO(9), .WAVES(3), .SCORE_DIGITS(1), .FLY_FRAMES(4), .PAUSE_FRAMES(2)
  ) u_dut2 (
    .clk(clk), .rst(rst_n), .new_frame(nf2), .start(st2), .shot_fired(sh2),
    .hit(h2), .hit_id(id2), .duck_launch(l2), .duck_active(a2), .ammo_bcd(am2),
    .score_bcd(sc2), .wave_bcd(wv2), .state(s2), .game_over(go2)
  );

  typedef struct {
    int nd; int ammo; int waves; int digits; int fly; int pause; bit bonus_en;
  } cfg_t;

  typedef struct {
    int st; int ammo; int score; int wave; bit [3:0] act; bit [3:0] lau; int fc; int bonus;
  } mdl_t;

  cfg_t c1 = '{2, 3, 10, 2, 300, 60, BONUS};
  cfg_t c2 = '{4, 9, 3, 1, 4, 2, BONUS};
  mdl_t m1, m2;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  function automatic int to_bcd(input int v);
    int r = 0;
    for (int k = 0; k < 4; k++) begin
      r = r | ((v % 10) << (4 * k));
      v = v / 10;
    end
    return r;
  endfunction

  // Game rules applied one clock at a time on plain integers.
  function automatic mdl_t step(input cfg_t c, input mdl_t s, input bit rn, input bit nf,
                                input bit stt, input bit sh, input bit h, input int id);
    mdl_t n;
    int   smax;
    bit   hv;
    bit   tmo;
    n     = s;
    n.lau = '0;
    smax  = 1;
    for (int i = 0; i < c.digits; i++) smax = smax * 10;
    smax = smax - 1;
    if (!rn) begin
      n.st = 0; n.ammo = c.ammo; n.score = 0; n.wave = 0;
      n.act = '0; n.fc = 0; n.bonus = 0;
      return n;
    end
    case (s.st)
      0, 4: if (stt) begin
        n.st = 1; n.score = 0; n.wave = 1; n.ammo = c.ammo; n.bonus = 0;
      end
      1: begin
        n.st = 2; n.act = 4'((1 << c.nd) - 1); n.lau = n.act; n.fc = 0;
      end
      2: begin
        hv = h && (id < c.nd) && s.act[id];
        if (sh && s.ammo > 0) n.ammo = s.ammo - 1;
        if (hv) begin
          n.act[id] = 1'b0;
          if (s.score < smax) n.score = s.score + 1;
        end
        tmo = nf && (s.fc == c.fly - 1);
        if (nf) n.fc = s.fc + 1;
        if (n.act == 0 || (n.ammo == 0 && !h) || tmo) begin
          if (c.bonus_en && n.act == 0) n.bonus = c.nd;
          n.act = '0; n.fc = 0; n.st = 3;
        end
      end
      3: begin
        if (s.bonus > 0) begin
          n.bonus = s.bonus - 1;
          if (n.score < smax) n.score = n.score + 1;
        end
        if (nf) begin
          if (s.fc == c.pause - 1) begin
            n.fc = 0; n.bonus = 0;
            if (s.wave == c.waves) n.st = 4;
            else begin n.wave = s.wave + 1; n.ammo = c.ammo; n.st = 1; end
          end else begin
            n.fc = s.fc + 1;
          end
        end
      end
      default: ;
    endcase
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    m1 <= step(c1, m1, rst_n, nf1, st1, sh1, h1, int'(id1));
    m2 <= step(c2, m2, rst_n, nf2, st2, sh2, h2, int'(id2));
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m1.state", 32'(s1), m1.st);
      chk("m1.launch", 32'(l1), int'(m1.lau));
      chk("m1.active", 32'(a1), int'(m1.act));
      chk("m1.ammo", 32'(am1), to_bcd(m1.ammo));
      chk("m1.score", 32'(sc1), to_bcd(m1.score));
      chk("m1.wave", 32'(wv1), to_bcd(m1.wave));
      chk("m1.over", 32'(go1), int'(m1.st == 4));
      chk("m2.state", 32'(s2), m2.st);
      chk("m2.launch", 32'(l2), int'(m2.lau));
      chk("m2.active", 32'(a2), int'(m2.act));
      chk("m2.ammo", 32'(am2), to_bcd(m2.ammo));
      chk("m2.score", 32'(sc2), to_bcd(m2.score));
      chk("m2.wave", 32'(wv2), to_bcd(m2.wave));
      chk("m2.over", 32'(go2), int'(m2.st == 4));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse1(input bit nf, input bit stt, input bit sh, input bit h, input bit id);
    nf1 = nf; st1 = stt; sh1 = sh; h1 = h; id1 = id;
    @(negedge clk);
    nf1 = 1'b0; st1 = 1'b0; sh1 = 1'b0; h1 = 1'b0; id1 = 1'b0;
  endtask

  task automatic pulse2(input bit nf, input bit stt, input bit h, input logic [1:0] id);
    nf2 = nf; st2 = stt; h2 = h; id2 = id;
    @(negedge clk);
    nf2 = 1'b0; st2 = 1'b0; h2 = 1'b0; id2 = 2'd0;
  endtask

  task automatic frames1(input int n);
    repeat (n) begin pulse1(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick(1); end
  endtask

  task automatic frames2(input int n);
    repeat (n) begin pulse2(1'b1, 1'b0, 1'b0, 2'd0); tick(1); end
  endtask

  task automatic chk_reset1(input string tag);
    chk({tag, ".state"}, 32'(s1), 0);
    chk({tag, ".ammo"}, 32'(am1), 3);
    chk({tag, ".score"}, 32'(sc1), 0);
    chk({tag, ".wave"}, 32'(wv1), 0);
    chk({tag, ".launch"}, 32'(l1), 0);
    chk({tag, ".active"}, 32'(a1), 0);
    chk({tag, ".over"}, 32'(go1), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    nf1 = 1'b0; st1 = 1'b0; sh1 = 1'b0; h1 = 1'b0; id1 = 1'b0;
    nf2 = 1'b0; st2 = 1'b0; sh2 = 1'b0; h2 = 1'b0; id2 = 2'd0;
    tick(2);
    chk_en = 1'b1;
    chk_reset1("reset");
    rst_n = 1'b1;

    // Start: one LAUNCH cycle, then FLY with launch pulse.
    pulse1(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("start.launch_state", 32'(s1), 1);
    tick(1);
    chk("fly.state", 32'(s1), 2);
    chk("fly.launch", 32'(l1), 3);
    chk("fly.active", 32'(a1), 3);
    chk("fly.ammo", 32'(am1), 3);
    chk("fly.wave", 32'(wv1), 8'h01);
    tick(1);
    chk("fly.launch_gone", 32'(l1), 0);

    // Wave 1: two hits with two shots clears the wave.
    pulse1(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("hit0.score", 32'(sc1), 8'h01);
    chk("hit0.active", 32'(a1), 2'b10);
    pulse1(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("hit1.score", 32'(sc1), 8'h02);
    chk("hit1.ammo", 32'(am1), 1);
    chk("hit1.active", 32'(a1), 0);
    chk("hit1.pause", 32'(s1), 3);
    tick(2);
    chk("pause.score", 32'(sc1), SC_W1);
    pulse1(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pause.start_ignored", 32'(s1), 3);
    frames1(60);
    chk("w2.state", 32'(s1), 2);
    chk("w2.wave", 32'(wv1), 8'h02);
    chk("w2.ammo", 32'(am1), 3);

    // Wave 2: ammo runs out, extra shot ignored.
    repeat (3) pulse1(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("dry.ammo", 32'(am1), 0);
    chk("dry.state", 32'(s1), 3);
    pulse1(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("dry.extra_shot", 32'(am1), 0);
    chk("dry.score", 32'(sc1), SC_W1);
    frames1(60);

    // Wave 3: timeout on the 300th frame.
    frames1(299);
    chk("tmo.299_state", 32'(s1), 2);
    chk("tmo.299_active", 32'(a1), 3);
    pulse1(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tmo.300_active", 32'(a1), 0);
    chk("tmo.300_state", 32'(s1), 3);
    frames1(60);
    chk("w4.wave", 32'(wv1), 8'h04);
    chk("w4.ammo", 32'(am1), 3);

    // Wave 4: repeated hit on the same duck scores once, then reset mid-FLY.
    pulse1(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("dup.first", 32'(sc1), SC_W1 + 1);
    pulse1(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("dup.second", 32'(sc1), SC_W1 + 1);
    chk("dup.active", 32'(a1), 2'b10);
    rst_n = 1'b0;
    tick(1);
    chk_reset1("midrst");
    rst_n = 1'b1;

    // Full game to OVER; last round shot together with a hit.
    pulse1(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    pulse1(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("fly.start_ignored", 32'(s1), 2);
    pulse1(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse1(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse1(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("last.ammo", 32'(am1), 0);
    chk("last.score", 32'(sc1), 8'h01);
    chk("last.still_fly", 32'(s1), 2);
    tick(1);
    chk("last.pause", 32'(s1), 3);
    frames1(60);
    for (int w = 2; w <= 10; w++) begin
      repeat (3) pulse1(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      frames1(60);
    end
    chk("over.state", 32'(s1), 4);
    chk("over.flag", 32'(go1), 1);
    chk("over.wave", 32'(wv1), 8'h10);
    tick(3);
    chk("over.score_held", 32'(sc1), 8'h01);
    pulse1(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("restart.state", 32'(s1), 1);
    chk("restart.score", 32'(sc1), 8'h00);
    chk("restart.wave", 32'(wv1), 8'h01);
    tick(1);

    // Small instance: single score digit saturates at 9.
    pulse2(1'b0, 1'b1, 1'b0, 2'd0);
    tick(1);
    for (int w = 0; w < 2; w++) begin
      for (int d = 0; d < 4; d++) pulse2(1'b0, 1'b0, 1'b1, 2'(d));
      frames2(2);
    end
    pulse2(1'b0, 1'b0, 1'b1, 2'd0);
    pulse2(1'b0, 1'b0, 1'b1, 2'd1);
    chk("sat.score", 32'(sc2), 4'h9);
    chk("sat.active", 32'(a2), 4'b1100);
    pulse2(1'b0, 1'b0, 1'b1, 2'd2);
    pulse2(1'b0, 1'b0, 1'b1, 2'd3);
    frames2(2);
    chk("sat.over", 32'(s2), 4);
    chk("sat.over_flag", 32'(go2), 1);
    chk("sat.final_score", 32'(sc2), 4'h9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ctl_game.md
# ctl_game

Parametrised game-flow controller for Duck Hunt. It replaces the constant ammo/score digits and the free-running single-duck flow with a round state machine. The controller launches waves of `NUM_DUCKS` ducks, counts ammunition per wave, accumulates a BCD score and ends the game after `WAVES` waves. It sits between `ctl_trigger` (hit/shot pulses) and `ctl_duck` instances / `disp_hex_mux`, all on the 65 MHz `clk` domain.

## Interface
Parameters:
- `NUM_DUCKS`, 2: ducks per wave, 1..4.
- `AMMO`, 3: shots per wave, 1..9.
- `WAVES`, 10: waves per game, 1..99.
- `SCORE_DIGITS`, 2: BCD score digits, 1..4.
- `FLY_FRAMES`, 300: frames before remaining ducks escape.
- `PAUSE_FRAMES`, 60: frames between waves.

Ports:
- `clk`  in  1: system clock, 65 MHz.
- `rst`  in  1: synchronous, active-low reset.
- `new_frame`  in  1: one-cycle pulse per VGA frame.
- `start`  in  1: pulse; starts a game from IDLE or OVER.
- `shot_fired`  in  1: one-cycle pulse from `ctl_trigger`.
- `hit`  in  1: one-cycle pulse, qualified by `hit_id`.
- `hit_id`  in  IDW: index of the hit duck, where IDW = max(1, $clog2(NUM_DUCKS)).
- `duck_launch`  out  NUM_DUCKS: one-cycle launch pulse per duck.
- `duck_active`  out  NUM_DUCKS: duck is flying and hittable.
- `ammo_bcd`  out  4: remaining shots.
- `score_bcd`  out  4*SCORE_DIGITS: score, digit 0 in LSBs.
- `wave_bcd`  out  8: current wave number, 1-based.
- `state`  out  3: IDLE=0, LAUNCH=1, FLY=2, PAUSE=3, OVER=4.
- `game_over`  out  1: high in OVER.

## Operation
States and transitions:
- IDLE: waits for `start`, then goes to LAUNCH. On entry the score is cleared, wave=1 and ammo=AMMO.
- LAUNCH: lasts exactly one cycle. `duck_launch` = all ones, `duck_active` is set to all ones and the frame counter is cleared. Then goes to FLY.
- FLY:
  - `shot_fired` with ammo>0 decrements ammo. `shot_fired` with ammo=0 is ignored.
  - `hit` with `duck_active[hit_id]`=1 clears that bit and adds 1 to the score. `hit` on an inactive or out-of-range id is ignored.
  - FLY exits to PAUSE at the first cycle where any of these holds: `duck_active`==0; ammo==0 with no hit pending that cycle; frame counter == FLY_FRAMES-1 on a `new_frame`.
  - On exit, all `duck_active` bits clear (remaining ducks escape).
- PAUSE: counts `new_frame` pulses up to PAUSE_FRAMES.
  - If wave==WAVES, goes to OVER.
  - Otherwise wave+1, ammo=AMMO, then goes to LAUNCH.
- OVER: holds the score. `start` goes to IDLE-entry actions, then LAUNCH on the next cycle.

Arithmetic rules:
- The score is a BCD ripple counter that saturates at all nines. An increment at saturation has no effect.
- `wave_bcd` is two BCD digits.
- `ammo_bcd` is never negative.

Simultaneous events and mid-operation behaviour:
- `hit` and `shot_fired` in the same cycle: both apply. If that shot uses the last round, the hit still scores.
- `start` outside IDLE/OVER is ignored.
- `rst` asserted in any state returns the block to IDLE on the next edge.

## Timing
- All outputs are registered. Each input pulse is reflected on the outputs 1 cycle after the sampling edge.
- Reset values: `state`=IDLE, `duck_launch`=0, `duck_active`=0, `ammo_bcd`=AMMO, `score_bcd`=0, `wave_bcd`=0, `game_over`=0.
- `duck_launch` is high for exactly the one cycle that follows LAUNCH.
- The frame counters advance only on `new_frame`. FLY timeout latency is FLY_FRAMES frames from the LAUNCH cycle.
- The FLY→PAUSE decision is made in the same cycle as the triggering event. `state` shows PAUSE one cycle later.

## Configuration
- `GAME_PERFECT_BONUS_EN` defined: if every duck of a wave is hit before FLY exits, NUM_DUCKS bonus points are added. The bonus is added one increment per cycle during the first NUM_DUCKS cycles of PAUSE and is subject to saturation.
- `GAME_PERFECT_BONUS_EN` undefined: there is no bonus logic, and the score changes only on hits.

## Test plan
- Reset, then `start`: LAUNCH for 1 cycle, `duck_launch`=2'b11, then FLY with `ammo_bcd`=3, `score_bcd`=8'h00, `wave_bcd`=8'h01.
- In FLY, `hit` id 0, then id 1 with 2 shots: score=8'h02, ammo=1, `duck_active`=0 → PAUSE. With the bonus macro the score reaches 8'h04 after 2 PAUSE cycles.
- Three `shot_fired` with no hits: ammo 3→0, then PAUSE; a 4th shot is ignored; score stays 8'h00.
- Run with no shots for 300 `new_frame` pulses: `duck_active` clears on the 300th frame and the block goes to PAUSE. After 60 frames `wave_bcd`=8'h02 and ammo=3.
- Preload score to 8'h99, then a valid hit: score stays 8'h99. After wave 10 PAUSE: `game_over`=1 and `state`=4. `start` restarts with score 8'h00.
- Hit the same id twice, and hit an inactive id: only the first hit scores. Assert `rst` low mid-FLY: all outputs equal their reset values on the next cycle.
